tcon_sel_fifo: RTL and testbench

- Parametrised, registered successor to the 8-bit two-bus transfer-control selector.
- Each accepted beat carries a primary bus A, an override bus B and a select bit. The block stores two results per beat:
  - pass result = A
  - mux result = sel ? B : A
- Results sit in a small output FIFO with valid/ready handshakes on both sides.
- A saturating override counter records how many beats took B.
- Sits between a bus producer and a downstream consumer that may stall.

---
 rtl/tcon_pkg.sv | 34 +++
 rtl/tcon_fifo_store.sv | 56 +++++
 rtl/tcon_sel_fifo.sv | 90 +++++++++
 tb/tb_tcon_sel_fifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcon_pkg.sv
// Shared constants, entry layout and select helper for the tcon_sel_fifo slice.
// Optional parity bit per entry is enabled by defining TCON_SEL_PARITY_EN.
package tcon_pkg;

  localparam int TCON_WIDTH = 8;
  localparam int TCON_DEPTH = 2;
  localparam int TCON_CNT_W = 16;

`ifdef TCON_SEL_PARITY_EN
  localparam int TCON_PAR_W = 1;
`else
  localparam int TCON_PAR_W = 0;
`endif

  // Entry layout at the default bus width: {pass, mux[, par]}, pass in the MSBs.
  typedef struct packed {
    logic [TCON_WIDTH-1:0] pass;
    logic [TCON_WIDTH-1:0] mux;
`ifdef TCON_SEL_PARITY_EN
    logic                  par;
`endif
  } tcon_entry_t;

  // Same layout width for an arbitrary bus width.
  function automatic int tcon_entry_w(input int width);
    return 2 * width + TCON_PAR_W;
  endfunction

  // Bit-slice of the transfer-control selector: sel picks the override bus.
  function automatic logic tcon_sel(input logic sel, input logic a, input logic b);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/tcon_fifo_store.sv
// DEPTH-entry register FIFO with wrap-around pointers and an occupancy count.
// Head data reads as zero while empty. Entry width includes parity under TCON_SEL_PARITY_EN.
module tcon_fifo_store #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic [OCC_W-1:0]  o_count,
  output logic              o_not_full,
  output logic              o_not_empty
);

  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_count;

  // NOTE: storage has no reset; stale contents are never visible because the
  // head is gated to zero while empty, and a reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_not_empty = (r_count != '0);
  assign o_not_full  = (r_count != FULL_CNT);
  assign o_count     = r_count;
  assign o_data      = o_not_empty ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/tcon_sel_fifo.sv
// Registered two-bus selector: stores {A, sel ? B : A} per beat in an output FIFO
// and counts override beats. Define TCON_SEL_PARITY_EN to add the out_par port.
module tcon_sel_fifo
  import tcon_pkg::*;
#(
  parameter int WIDTH = TCON_WIDTH,
  parameter int DEPTH = TCON_DEPTH,
  parameter int CNT_W = TCON_CNT_W,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pass,
  output logic [WIDTH-1:0] out_mux,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] ovr_cnt,
`ifdef TCON_SEL_PARITY_EN
  output logic             out_par,
`endif
  input  logic             clr_cnt
);

  localparam int               ENTRY_W = tcon_entry_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               w_push;
  logic               w_pop;
  logic [WIDTH-1:0]   w_mux;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_rd_entry;
  logic [CNT_W-1:0]   r_ovr_cnt;

  // in_ready comes straight from stored occupancy, so a pop never frees a
  // slot for a push in the same cycle.
  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // NOTE: combinational outputs get a default before the loop so no path
  // leaves them unassigned and no latch is inferred.
  always_comb begin
    w_mux = '0;
    for (int i = 0; i < WIDTH; i++) w_mux[i] = tcon_sel(in_sel, in_a[i], in_b[i]);
  end

`ifdef TCON_SEL_PARITY_EN
  assign w_wr_entry = {in_a, w_mux, ^w_mux};
  assign out_par    = w_rd_entry[0];
`else
  assign w_wr_entry = {in_a, w_mux};
`endif

  tcon_fifo_store #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (w_wr_entry),
    .o_data      (w_rd_entry),
    .o_count     (occupancy),
    .o_not_full  (in_ready),
    .o_not_empty (out_valid)
  );

  assign out_pass = w_rd_entry[ENTRY_W-1 -: WIDTH];
  assign out_mux  = w_rd_entry[ENTRY_W-WIDTH-1 -: WIDTH];

  // Clear has priority over a same-edge increment; the count holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr_cnt <= '0;
    end else if (clr_cnt) begin
      r_ovr_cnt <= '0;
    end else if (w_push && in_sel && (r_ovr_cnt != CNT_MAX)) begin
      r_ovr_cnt <= r_ovr_cnt + 1'b1;
    end
  end

  assign ovr_cnt = r_ovr_cnt;

endmodule

// File: tb/tb_tcon_sel_fifo.sv
// Scoreboard bench for tcon_sel_fifo (DEPTH=2, CNT_W=4): a queue-based model
// tracks stored beats and the override count; directed sequences plus random traffic.
module tb_tcon_sel_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pass;
  logic [WIDTH-1:0] out_mux;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] ovr_cnt;
  logic             clr_cnt;
`ifdef TCON_SEL_PARITY_EN
  logic             out_par;
`endif

  tcon_sel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pass  (out_pass),
    .out_mux   (out_mux),
    .occupancy (occupancy),
    .ovr_cnt   (ovr_cnt),
`ifdef TCON_SEL_PARITY_EN
    .out_par   (out_par),
`endif
    .clr_cnt   (clr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] pass;
    logic [WIDTH-1:0] mux;
    logic             par;
  } exp_t;

  exp_t q[$];
  int   m_cnt   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/model: compare DUT state against the model, then advance the model
  // from the inputs that will be sampled on the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_out_mux",   32'(out_mux),   32'd0);
      check("rst_ovr_cnt",   32'(ovr_cnt),   32'd0);
      q.delete();
      m_cnt = 0;
    end else begin
      bit   push_m;
      bit   pop_m;
      exp_t e;
      check("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("occupancy", 32'(occupancy), 32'(q.size()));
      check("ovr_cnt",   32'(ovr_cnt),   32'(m_cnt));
      if (q.size() != 0) begin
        check("head_pass", 32'(out_pass), 32'(q[0].pass));
        check("head_mux",  32'(out_mux),  32'(q[0].mux));
`ifdef TCON_SEL_PARITY_EN
        check("head_par",  32'(out_par),  32'(q[0].par));
`endif
      end else begin
        check("empty_pass", 32'(out_pass), 32'd0);
        check("empty_mux",  32'(out_mux),  32'd0);
`ifdef TCON_SEL_PARITY_EN
        check("empty_par",  32'(out_par),  32'd0);
`endif
      end
      push_m = in_valid && (q.size() < DEPTH);
      pop_m  = out_ready && (q.size() != 0);
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        e.pass = in_a;
        e.mux  = in_sel ? in_b : in_a;
        e.par  = ^e.mux;
        q.push_back(e);
      end
      if (clr_cnt) m_cnt = 0;
      else if (push_m && in_sel && m_cnt < CMAX) m_cnt = m_cnt + 1;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    in_valid = v;
    in_sel   = s;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic idle();
    drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && occupancy != '0; i++) cycle();
    check("drain_empty", 32'(occupancy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; clr_cnt = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Single beat with one-cycle latency.
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h3C, 8'hA5);
    cycle();
    idle();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_pass",  32'(out_pass),  32'h3C);
    check("single_mux",   32'(out_mux),   32'hA5);
    check("single_cnt",   32'(ovr_cnt),   32'd1);
    cycle();
    check("single_gone",  32'(out_valid), 32'd0);

    // Backpressure until full; a third beat must be refused.
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h11, 8'($urandom));
    cycle();
    drive(1'b1, 1'b1, 8'h22, 8'h99);
    cycle();
    check("full_occ",   32'(occupancy), 32'd2);
    check("full_ready", 32'(in_ready),  32'd0);
    drive(1'b1, 1'b1, 8'h33, 8'h44);
    repeat (2) cycle();
    check("full_hold_occ", 32'(occupancy), 32'd2);
    check("full_hold_mux", 32'(out_mux),   32'h11);
    idle();
    out_ready = 1'b1;
    cycle();
    check("pop1_ready", 32'(in_ready), 32'd1);
    check("pop1_mux",   32'(out_mux),  32'h99);
    cycle();
    check("pop2_empty", 32'(out_valid), 32'd0);

    // Steady push+pop at occupancy 1 across pointer wrap.
    out_ready = 1'b0;
    drive(1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
      cycle();
      check("stream_occ", 32'(occupancy), 32'd1);
    end
    drain();

    // Counter saturation, then clear beating a same-edge increment.
    clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    check("clr_idle", 32'(ovr_cnt), 32'd0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 8'($urandom), 8'($urandom));
      cycle();
    end
    check("sat_cnt", 32'(ovr_cnt), 32'(CMAX));
    clr_cnt = 1'b1;
    drive(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    cycle();
    clr_cnt = 1'b0;
    check("clr_wins", 32'(ovr_cnt), 32'd0);
    drain();

    // Parity beats (checked only when the parity port exists).
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h07, 8'($urandom));
    cycle();
    check("par_mux07", 32'(out_mux), 32'h07);
`ifdef TCON_SEL_PARITY_EN
    check("par_07", 32'(out_par), 32'd1);
`endif
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 8'($urandom), 8'h03);
    cycle();
    check("par_mux03", 32'(out_mux), 32'h03);
`ifdef TCON_SEL_PARITY_EN
    check("par_03", 32'(out_par), 32'd0);
`endif
    drain();

    // Random traffic with occasional counter clears.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 8'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      clr_cnt   = ($urandom_range(0, 39) == 0);
      cycle();
    end
    clr_cnt = 1'b0;
    drain();

    // Asynchronous reset while full.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 8'($urandom), 8'($urandom));
      cycle();
    end
    check("pre_rst_occ", 32'(occupancy), 32'd2);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_occ",   32'(occupancy), 32'd0);
    check("async_pass",  32'(out_pass),  32'd0);
    check("async_mux",   32'(out_mux),   32'd0);
    check("async_cnt",   32'(ovr_cnt),   32'd0);
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h5A, 8'hC3);
    cycle();
    idle();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_mux",   32'(out_mux),   32'hC3);
    check("post_rst_pass",  32'(out_pass),  32'h5A);
    drain();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
